// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the fetch-side PC redirect controller.
// State encodings, PC increment and default reset vector.
package pc_redirect_ctrl_pkg;

  typedef enum logic [0:0] {
    PCS_RUN  = 1'b0,
    PCS_HALT = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CntMax = {W{1'b1}};
  localparam logic [W-1:0] CntOne = W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (inc && (cnt != CntMax)) begin
      cnt <= cnt + CntOne;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC register and redirect/stall/squash control for the IF stage.
// Traps into HALT on a misaligned redirect target; exit only via reset.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_flush,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_target,
  output logic [31:0]      pc,
  output logic             if_valid,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;
  logic        redirect;
  logic        misaligned;
  logic        redirect_inc;
  logic        stall_inc;

  // ALU flush is stale on non-branch ops, so it only counts when qualified by ex_is_branch.
  assign redirect   = ex_valid & ((ex_is_branch & ex_flush) | ex_is_jump);
  assign misaligned = (ex_target[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    redirect_inc = 1'b0;
    stall_inc    = 1'b0;
    unique case (state_q)
      PCS_RUN: begin
        if (redirect && misaligned) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = PCS_HALT;
        end else if (redirect) begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          pc_d         = ex_target;
          redirect_inc = 1'b1;
        end else if (stall) begin
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (if_valid_q) begin
          // First edge after reset only raises if_valid; pc stays at the reset vector.
          pc_d = pc_q + PC_INC;
        end
      end
      PCS_HALT: begin
        state_d = PCS_HALT;
      end
      default: begin
        state_d = PCS_HALT;
      end
    endcase
    if_valid_d = (state_d == PCS_RUN);
    halted_d   = (state_d == PCS_HALT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= PCS_RUN;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (redirect_inc),
    .cnt  (redirect_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  assign pc       = pc_q;
  assign if_valid = if_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_flush;
  logic        ex_is_jump;
  logic [31:0] ex_target;
  logic [31:0] pc;
  logic        if_valid;
  logic        ifid_flush;
  logic        idex_flush;
  logic        halted;
  logic [15:0] redirect_cnt;
  logic [15:0] stall_cnt;

  int checks;
  int errors;

  pc_redirect_ctrl #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_flush     (ex_flush),
    .ex_is_jump   (ex_is_jump),
    .ex_target    (ex_target),
    .pc           (pc),
    .if_valid     (if_valid),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .halted       (halted),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall        = 1'b0;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_flush     = 1'b0;
    ex_is_jump   = 1'b0;
    ex_target    = 32'h0;
  endtask

  task automatic chk_flush(input string tag, input logic ifid_exp, input logic idex_exp);
    #1;
    chk({tag, "_ifid"}, {31'b0, ifid_flush}, {31'b0, ifid_exp});
    chk({tag, "_idex"}, {31'b0, idex_flush}, {31'b0, idex_exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    idle_inputs();

    // Reset state
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_redirect_cnt", {16'b0, redirect_cnt}, 32'h0);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    rstn = 1'b1;

    // Warm-up edge keeps pc, then sequential fetch
    tick();
    chk("warm_pc", pc, 32'h0);
    chk("warm_if_valid", {31'b0, if_valid}, 32'h1);
    tick();
    chk("seq_pc4", pc, 32'h4);
    tick();
    chk("seq_pc8", pc, 32'h8);

    // Two-cycle load-use stall at pc=8
    stall = 1'b1;
    chk_flush("stall1", 1'b0, 1'b1);
    tick();
    chk("stall1_pc", pc, 32'h8);
    chk("stall1_cnt", {16'b0, stall_cnt}, 32'h1);
    chk_flush("stall2", 1'b0, 1'b1);
    tick();
    chk("stall2_pc", pc, 32'h8);
    chk("stall2_cnt", {16'b0, stall_cnt}, 32'h2);
    stall = 1'b0;
    tick();
    chk("post_stall_pc", pc, 32'hC);
    tick();
    chk("seq_pc10", pc, 32'h10);

    // Taken beq at pc=0x10 to 0x40
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_flush     = 1'b1;
    ex_target    = 32'h40;
    chk_flush("beq", 1'b1, 1'b1);
    tick();
    chk("beq_pc", pc, 32'h40);
    chk("beq_redirect_cnt", {16'b0, redirect_cnt}, 32'h1);

    // Stale ALU flush on a non-branch must be ignored
    ex_is_branch = 1'b0;
    ex_target    = 32'h80;
    chk_flush("stale_flush", 1'b0, 1'b0);
    tick();
    chk("stale_flush_pc", pc, 32'h44);
    chk("stale_flush_cnt", {16'b0, redirect_cnt}, 32'h1);

    // Stall and jal in the same cycle: redirect wins, stall not counted
    ex_flush   = 1'b0;
    ex_is_jump = 1'b1;
    ex_target  = 32'h100;
    stall      = 1'b1;
    chk_flush("jal_stall", 1'b1, 1'b1);
    tick();
    chk("jal_stall_pc", pc, 32'h100);
    chk("jal_stall_redirect_cnt", {16'b0, redirect_cnt}, 32'h2);
    chk("jal_stall_stall_cnt", {16'b0, stall_cnt}, 32'h2);
    stall = 1'b0;

    // PC wrap from 0xFFFF_FFFC
    ex_target = 32'hFFFF_FFFC;
    tick();
    chk("jal_top_pc", pc, 32'hFFFF_FFFC);
    idle_inputs();
    tick();
    chk("wrap_pc", pc, 32'h0);

    // Misaligned jalr target 0x102 traps
    ex_valid   = 1'b1;
    ex_is_jump = 1'b1;
    ex_target  = 32'h102;
    chk_flush("misalign", 1'b1, 1'b1);
    tick();
    chk("halt_halted", {31'b0, halted}, 32'h1);
    chk("halt_if_valid", {31'b0, if_valid}, 32'h0);
    chk("halt_pc", pc, 32'h0);
    chk("halt_redirect_cnt", {16'b0, redirect_cnt}, 32'h3);

    // Inputs ignored while halted
    ex_target = 32'h200;
    stall     = 1'b1;
    chk_flush("halt_in", 1'b0, 1'b0);
    tick();
    tick();
    chk("halt_hold_pc", pc, 32'h0);
    chk("halt_hold_halted", {31'b0, halted}, 32'h1);
    chk("halt_hold_redirect_cnt", {16'b0, redirect_cnt}, 32'h3);
    chk("halt_hold_stall_cnt", {16'b0, stall_cnt}, 32'h2);

    // Reset pulse leaves HALT
    idle_inputs();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst2_halted", {31'b0, halted}, 32'h0);
    chk("rst2_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    rstn = 1'b1;
    tick();
    chk("rst2_if_valid", {31'b0, if_valid}, 32'h1);

    // Redirect counter saturation
    ex_valid   = 1'b1;
    ex_is_jump = 1'b1;
    ex_target  = 32'h200;
    repeat (65534) tick();
    chk("sat_near", {16'b0, redirect_cnt}, 32'hFFFE);
    tick();
    chk("sat_max", {16'b0, redirect_cnt}, 32'hFFFF);
    tick();
    chk("sat_hold", {16'b0, redirect_cnt}, 32'hFFFF);
    chk("sat_pc", pc, 32'h200);

    // Asynchronous reset asserted mid-stall
    idle_inputs();
    stall = 1'b1;
    tick();
    chk("pre_rst_stall_cnt", {16'b0, stall_cnt}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("midrst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("midrst_redirect_cnt", {16'b0, redirect_cnt}, 32'h0);
    chk("midrst_halted", {31'b0, halted}, 32'h0);
    idle_inputs();
    rstn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Fetch-side consumer of the EX-stage branch/jump decision in the 5-stage RV32I pipeline.
- Owns the PC register and applies redirects from EX (ALU branch-taken `flush`, jal/jalr).
- Holds fetch on ID load-use stalls and generates the squash pulses for IF/ID and ID/EX.
- Halts fetch on a misaligned redirect target; keeps saturating performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- stall  input  1  ID load-use hazard; hold PC and IF/ID.
- ex_valid  input  1  EX holds a real (non-bubble) instruction.
- ex_is_branch  input  1  EX instruction is a B-type.
- ex_flush  input  1  branch taken, from the ALU; meaningful only when ex_is_branch.
- ex_is_jump  input  1  EX instruction is jal/jalr (always taken).
- ex_target  input  32  redirect target computed in EX.
- pc  output  32  current fetch address, to instruction memory.
- if_valid  output  1  fetched word is valid for IF/ID.
- ifid_flush  output  1  squash IF/ID at the next edge.
- idex_flush  output  1  squash ID/EX at the next edge.
- halted  output  1  misaligned-target trap; fetch stopped.
- redirect_cnt  output  CNT_W  taken redirects, saturating.
- stall_cnt  output  CNT_W  stall cycles honoured, saturating.

Behaviour:
- Reset (rstn low, async): pc=RESET_PC, state=RUN, halted=0, both counters=0, if_valid=0.
  - First rising edge after release sets if_valid=1; pc stays RESET_PC for that edge.
- States:
  - RUN: normal fetch.
  - HALT: trapped. Exit only through reset.
- redirect = ex_valid & ((ex_is_branch & ex_flush) | ex_is_jump), combinational.
- RUN, per cycle, priority highest first:
  - redirect with ex_target[1:0]!=0:
    - ifid_flush=1, idex_flush=1 this cycle.
    - next state HALT, pc unchanged, redirect_cnt unchanged.
  - redirect (aligned):
    - ifid_flush=1, idex_flush=1 combinationally this cycle.
    - pc<=ex_target at the edge; redirect_cnt+1.
    - Fetch of the target is visible the cycle after (penalty 2 instructions).
  - stall:
    - pc holds; ifid_flush=0; idex_flush=1 (bubble into EX); stall_cnt+1.
  - otherwise: pc<=pc+4, flushes 0.
- Redirect and stall in the same cycle: redirect wins.
  - The stalled instruction is younger and gets squashed.
  - stall_cnt is not incremented.
- ex_flush with ex_is_branch=0 is ignored; the ALU `flush` holds its last value on non-branch ops.
- HALT:
  - pc frozen, if_valid=0, halted=1, all flushes 0, counters frozen.
  - Inputs ignored.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no trap.
  - Counters saturate at all-ones.
- Reset asserted mid-redirect or mid-stall: immediate return to reset values; no partial update.
- All outputs except the flushes are registered; the flushes are combinational from inputs and state.

Decomposition:
- Shared package (alongside ctrl_encode_def.v):
  - state encodings `PCS_RUN` and `PCS_HALT`.
  - `PC_INC` = 4.
  - default RESET_PC.
- One sub-module: sat_counter (parameter W; inc enable; async active-low clear). Instantiated twice.

Test Plan:
- Reset release, no events, 4 cycles -> pc 0,0,4,8,C; if_valid 0 then 1; counters 0.
- Taken beq at pc=0x10: ex_valid=1, ex_is_branch=1, ex_flush=1, ex_target=0x40 -> same cycle ifid_flush=idex_flush=1; next pc=0x40; redirect_cnt=1.
- stall=1 for 2 cycles at pc=0x8 -> pc holds 0x8, idex_flush=1 each cycle, stall_cnt=2; then pc=0xC.
- stall=1 and jal to 0x100 in the same cycle -> pc=0x100, redirect_cnt=1, stall_cnt=0.
- ex_flush=1 with ex_is_branch=0 -> no redirect, pc+4. jalr to 0x102 -> halted=1, if_valid=0, pc frozen until rstn pulse.
- pc at 0xFFFF_FFFC -> next 0x0. Drive redirect_cnt to 0xFFFF, then one more redirect -> stays 0xFFFF. Assert rstn mid-stall -> all reset values asynchronously.
